// File: rtl/boton_evento.sv
// boton_evento: classifies a debounced button level into short, long and auto-repeat pulses.
// Optional macro BOTON_REPEAT_EN enables the repeat_press pulses while held.
module boton_evento #(
  parameter int LONG_TIME   = 25000000,
  parameter int REPEAT_TIME = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic short_press,
  output logic long_press,
  output logic repeat_press,
  output logic held
);
  localparam int MX = LONG_TIME > REPEAT_TIME ? LONG_TIME : REPEAT_TIME;
  localparam int CW = $clog2(MX);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] L1  = CW'(LONG_TIME - 1);
  typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic short_n, long_n;
`ifdef BOTON_REPEAT_EN
  localparam logic [CW-1:0] R1 = CW'(REPEAT_TIME - 1);
  logic rep_n;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    short_n = 1'b0;
    long_n  = 1'b0;
`ifdef BOTON_REPEAT_EN
    rep_n   = 1'b0;
`endif
    case (state)
      IDLE: if (btn_in) begin
        state_n = PRESS;
        cnt_n   = ONE;
      end
      PRESS: if (!btn_in) begin
        state_n = IDLE;
        short_n = 1'b1;
      end else if (cnt == L1) begin
        state_n = HOLD;
        long_n  = 1'b1;
        cnt_n   = '0;
      end else cnt_n = cnt + ONE;
      HOLD: if (!btn_in) state_n = IDLE;
`ifdef BOTON_REPEAT_EN
      else if (cnt == R1) begin
        rep_n = 1'b1;
        cnt_n = '0;
      end else cnt_n = cnt + ONE;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      short_press <= short_n;
      long_press  <= long_n;
      held        <= state_n != IDLE;
    end
  end
`ifdef BOTON_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) repeat_press <= 1'b0;
    else repeat_press <= rep_n;
  end
`else
  assign repeat_press = 1'b0;
`endif
endmodule
